// File: rtl/branch_resolve.sv
// Branch/jump resolution stage after the EXU compare unit: picks taken/not-taken,
// next PC and link, holds them behind a valid/ready output, and pulses flush on a
// consumed redirect. Optional macro BRU_STAT_EN adds branch/taken statistics counters.
module branch_resolve #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_imm,
   input  logic [XLEN-1:0] in_src1,
   input  logic [XLEN-1:0] in_cmp,
   input  logic            in_is_branch,
   input  logic            in_is_jal,
   input  logic            in_is_jalr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_link,
   output logic            out_redirect,
   output logic            out_misalign,
   output logic            flush
`ifdef BRU_STAT_EN
   ,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_taken
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_HOLD  = 2'd1;
   localparam logic [1:0] S_REDIR = 2'd2;

   logic [1:0]      r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_link;
   logic            r_redirect;
   logic            r_misalign;
   logic            r_flush;

   logic [XLEN-1:0] w_link;
   logic [XLEN-1:0] w_jalr_sum;
   logic [XLEN-1:0] w_target;
   logic            w_taken;
   logic            w_acc;
   logic            w_out_hs;
   logic            w_unused;

   assign w_link     = in_pc + XLEN'(4);
   assign w_jalr_sum = in_src1 + in_imm;
   // JALR wins over JAL/branch when several type flags are set
   assign w_target   = in_is_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : (in_pc + in_imm);
   assign w_taken    = in_is_jal | in_is_jalr | (in_is_branch & in_cmp[0]);
   assign w_unused   = ^{in_cmp[XLEN-1:1], w_jalr_sum[0]};

   always_comb begin
      in_ready = 1'b0;
      case (r_state)
         S_IDLE:  in_ready = 1'b1;
         S_HOLD:  in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
   end

   assign w_acc    = in_valid & in_ready;
   assign w_out_hs = out_valid & out_ready;

   // An accept in HOLD always coincides with the consumer draining the old result
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_link     <= '0;
         r_redirect <= 1'b0;
         r_misalign <= 1'b0;
         r_flush    <= 1'b0;
      end else begin
         r_flush <= (r_state == S_REDIR) & out_ready;
         if (w_acc) begin
            r_state    <= w_taken ? S_REDIR : S_HOLD;
            r_pc       <= w_taken ? w_target : w_link;
            r_link     <= w_link;
            r_redirect <= w_taken;
            r_misalign <= w_taken & w_target[1];
         end else if (w_out_hs) begin
            r_state <= S_IDLE;
         end
      end
   end

   assign out_valid    = (r_state != S_IDLE);
   assign out_pc       = r_pc;
   assign out_link     = r_link;
   assign out_redirect = r_redirect;
   assign out_misalign = r_misalign;
   assign flush        = r_flush;

`ifdef BRU_STAT_EN
   logic        r_is_br;
   logic [31:0] r_stat_br;
   logic [31:0] r_stat_tk;

   // Only a pure conditional branch counts; JAL/JALR take priority when mixed
   always_ff @(posedge clk) begin
      if (rst) begin
         r_is_br   <= 1'b0;
         r_stat_br <= '0;
         r_stat_tk <= '0;
      end else begin
         if (w_acc) r_is_br <= in_is_branch & ~in_is_jal & ~in_is_jalr;
         if (w_out_hs && r_is_br) begin
            r_stat_br <= r_stat_br + 32'd1;
            if (r_redirect) r_stat_tk <= r_stat_tk + 32'd1;
         end
      end
   end

   assign stat_branches = r_stat_br;
   assign stat_taken    = r_stat_tk;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: hand-computed vectors for branch/JAL/JALR,
// stall, flush timing and mid-operation reset.
module tb_branch_resolve;
   localparam int XLEN = 64;
   localparam logic [63:0] RST_PC = 64'h8000_0000;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid, in_ready;
   logic [XLEN-1:0] in_pc, in_imm, in_src1, in_cmp;
   logic            in_is_branch, in_is_jal, in_is_jalr;
   logic            out_valid, out_ready;
   logic [XLEN-1:0] out_pc, out_link;
   logic            out_redirect, out_misalign, flush;
`ifdef BRU_STAT_EN
   logic [31:0]     stat_branches, stat_taken;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   branch_resolve #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_imm(in_imm), .in_src1(in_src1), .in_cmp(in_cmp),
      .in_is_branch(in_is_branch), .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_link(out_link),
      .out_redirect(out_redirect), .out_misalign(out_misalign), .flush(flush)
`ifdef BRU_STAT_EN
      , .stat_branches(stat_branches), .stat_taken(stat_taken)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic v, input logic [63:0] pc, input logic [63:0] imm,
                      input logic [63:0] src1, input logic [63:0] cmp,
                      input logic br, input logic jal, input logic jalr);
      in_valid = v; in_pc = pc; in_imm = imm; in_src1 = src1; in_cmp = cmp;
      in_is_branch = br; in_is_jal = jal; in_is_jalr = jalr;
   endtask

   // result check for a just-registered output
   task automatic chk_out(input string tag, input logic [63:0] pc, input logic [63:0] link,
                          input logic redir, input logic mis);
      chk({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
      chk({tag, ".pc"}, out_pc, pc);
      chk({tag, ".link"}, out_link, link);
      chk({tag, ".redir"}, {63'd0, out_redirect}, {63'd0, redir});
      chk({tag, ".mis"}, {63'd0, out_misalign}, {63'd0, mis});
   endtask

   // redirect with out_ready=1: REDIR blocks input, then flush for exactly one cycle
   task automatic redir_drain(input string tag);
      chk({tag, ".rdy_redir"}, {63'd0, in_ready}, 64'd0);
      chk({tag, ".noflush"}, {63'd0, flush}, 64'd0);
      tick();
      chk({tag, ".flush"}, {63'd0, flush}, 64'd1);
      chk({tag, ".idle"}, {63'd0, out_valid}, 64'd0);
      chk({tag, ".rdy_flush"}, {63'd0, in_ready}, 64'd1);
      tick();
      chk({tag, ".flush_end"}, {63'd0, flush}, 64'd0);
   endtask

   initial begin
      rst = 1'b1; out_ready = 1'b1;
      drv(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
      tick(); tick();
      chk("rst.valid", {63'd0, out_valid}, 64'd0);
      chk("rst.pc", out_pc, RST_PC);
      chk("rst.link", out_link, 64'd0);
      chk("rst.redir", {63'd0, out_redirect}, 64'd0);
      chk("rst.mis", {63'd0, out_misalign}, 64'd0);
      chk("rst.flush", {63'd0, flush}, 64'd0);
      rst = 1'b0;

      // BEQ taken
      drv(1'b1, 64'h8000_0010, 64'h20, '0, '1, 1'b1, 1'b0, 1'b0);
      #1 chk("beq.rdy", {63'd0, in_ready}, 64'd1);
      tick(); in_valid = 1'b0;
      chk_out("beq", 64'h8000_0030, 64'h8000_0014, 1'b1, 1'b0);
      redir_drain("beq");

      // BNE not taken, back-to-back stream
      for (int i = 0; i < 3; i++) begin
         drv(1'b1, 64'h8000_0000 + 64'(8 * i), 64'h40, '0, '0, 1'b1, 1'b0, 1'b0);
         #1 chk("bne.rdy", {63'd0, in_ready}, 64'd1);
         tick();
         chk_out("bne", 64'h8000_0004 + 64'(8 * i), 64'h8000_0004 + 64'(8 * i), 1'b0, 1'b0);
         chk("bne.noflush", {63'd0, flush}, 64'd0);
      end
      in_valid = 1'b0;
      tick();
      chk("bne.idle", {63'd0, out_valid}, 64'd0);
      chk("bne.noflush2", {63'd0, flush}, 64'd0);

      // only cmp bit 0 matters
      drv(1'b1, 64'h1000, 64'h100, '0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0);
      tick(); in_valid = 1'b0;
      chk_out("cmpb0", 64'h1004, 64'h1004, 1'b0, 1'b0);
      tick();

      // JALR misaligned target
      drv(1'b1, 64'h8000_0200, 64'h0, 64'h8000_1003, '0, 1'b0, 1'b0, 1'b1);
      tick(); in_valid = 1'b0;
      chk_out("jalr", 64'h8000_1002, 64'h8000_0204, 1'b1, 1'b1);
      redir_drain("jalr");

      // JAL wrap-around
      drv(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10, '0, '0, 1'b0, 1'b1, 1'b0);
      tick(); in_valid = 1'b0;
      chk_out("jal", 64'h8, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0);
      redir_drain("jal");

      // all flags set: JALR target wins
      drv(1'b1, 64'h1000, 64'h10, 64'h2001, '0, 1'b1, 1'b1, 1'b1);
      tick(); in_valid = 1'b0;
      chk_out("prio", 64'h2010, 64'h1004, 1'b1, 1'b0);
      redir_drain("prio");

      // non-control passthrough
      drv(1'b1, 64'h100, 64'h7777, 64'h5555, '1, 1'b0, 1'b0, 1'b0);
      tick(); in_valid = 1'b0;
      chk_out("nop", 64'h104, 64'h104, 1'b0, 1'b0);
      tick();

      // taken branch stalled 5 cycles with in_valid held
      out_ready = 1'b0;
      drv(1'b1, 64'h8000_0100, 64'h40, '0, 64'h1, 1'b1, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk_out("stall", 64'h8000_0140, 64'h8000_0104, 1'b1, 1'b0);
         chk("stall.rdy", {63'd0, in_ready}, 64'd0);
         chk("stall.noflush", {63'd0, flush}, 64'd0);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("stall.flush", {63'd0, flush}, 64'd1);
      chk("stall.idle", {63'd0, out_valid}, 64'd0);
      tick();
      chk("stall.flush_end", {63'd0, flush}, 64'd0);

      // same stall, reset on cycle 3
      out_ready = 1'b0;
      drv(1'b1, 64'h8000_0100, 64'h40, '0, 64'h1, 1'b1, 1'b0, 1'b0);
      tick(); tick();
      chk("rstmid.held", {63'd0, out_valid}, 64'd1);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstmid.valid", {63'd0, out_valid}, 64'd0);
      chk("rstmid.pc", out_pc, RST_PC);
      chk("rstmid.noflush", {63'd0, flush}, 64'd0);
      tick();
      chk("rstmid.noflush2", {63'd0, flush}, 64'd0);
`ifdef BRU_STAT_EN
      chk("stat.rst_br", {32'd0, stat_branches}, 64'd0);
      chk("stat.rst_tk", {32'd0, stat_taken}, 64'd0);
`endif

      // three branches: taken, not-taken, taken
      for (int i = 0; i < 3; i++) begin
         drv(1'b1, 64'h9000_0000, 64'h80, '0, (i == 1) ? 64'h0 : 64'h1, 1'b1, 1'b0, 1'b0);
         tick(); in_valid = 1'b0;
         chk_out("br3", (i == 1) ? 64'h9000_0004 : 64'h9000_0080, 64'h9000_0004,
                 (i != 1), 1'b0);
         tick(); tick();
      end
`ifdef BRU_STAT_EN
      chk("stat.br", {32'd0, stat_branches}, 64'd3);
      chk("stat.tk", {32'd0, stat_taken}, 64'd2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Branch/jump resolution stage directly downstream of the ALU compare unit in the NPC EXU.
- Consumes the compare unit's 64-bit all-ones/all-zeros result together with the instruction's PC, immediate and rs1 value.
- Decides taken/not-taken, computes the next PC and the link value, and presents them to the IFU/WBU through a registered valid/ready output.
- On a taken redirect, blocks younger wrong-path instructions and emits a one-cycle flush.

Parameters:
- XLEN, 64, datapath width for PC, immediate, operand and link.
- RESET_PC, 64'h8000_0000, value held on out_pc while in reset.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  EXU offers an instruction
- in_ready  out  1  stage can accept this cycle
- in_pc  in  XLEN  instruction PC
- in_imm  in  XLEN  sign-extended immediate
- in_src1  in  XLEN  rs1 value (JALR base)
- in_cmp  in  XLEN  compare-unit result (all-ones = true, zero = false)
- in_is_branch  in  1  conditional branch (BEQ/BNE/BLT/BGE/BLTU/BGEU)
- in_is_jal  in  1  JAL
- in_is_jalr  in  1  JALR
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts
- out_pc  out  XLEN  next PC
- out_link  out  XLEN  in_pc+4, value for rd
- out_redirect  out  1  next PC is not in_pc+4
- out_misalign  out  1  taken target has bit 1 set
- flush  out  1  one-cycle pulse: kill younger instructions upstream

Behaviour:
- Reset (synchronous, highest priority): state=IDLE, out_valid=0, out_redirect=0, out_misalign=0, flush=0, out_link=0, out_pc=RESET_PC.
- Reset mid-operation discards any held result; no flush is issued.
- States:
  - IDLE: nothing held.
  - HOLD: non-redirect result held.
  - REDIR: redirect result held.
- Accept condition: acc = in_valid & in_ready.
- in_ready:
  - IDLE: 1.
  - HOLD: out_ready (pass-through; back-to-back at full throughput).
  - REDIR: 0, regardless of out_ready.
- Resolve (combinational, registered on acc):
  - taken = in_is_jal | in_is_jalr | (in_is_branch & in_cmp[0]). Only bit 0 of in_cmp is used.
  - target:
    - JAL/branch: in_pc + in_imm.
    - JALR: (in_src1 + in_imm) with bit 0 cleared.
  - All adds are modulo 2^XLEN (wrap-around, no overflow flag).
  - out_pc = taken ? target : in_pc + 4.
  - out_link = in_pc + 4 for every instruction.
  - out_redirect = taken.
  - out_misalign = taken & target[1].
  - A non-control instruction (all three type flags 0) passes through with redirect=0.
  - More than one type flag set: priority JALR > JAL > branch.
- Latency: 1 cycle from acc to out_valid=1.
- Output registers are stable while out_valid & !out_ready.
- Transitions:
  - IDLE --acc, !taken--> HOLD.
  - IDLE --acc, taken--> REDIR.
  - HOLD --out_ready & acc--> HOLD or REDIR, by new taken.
  - HOLD --out_ready & !acc--> IDLE.
  - REDIR --out_ready--> IDLE, with flush=1 in the following cycle only.
- flush is registered and lasts exactly 1 cycle per consumed redirect. In that flush cycle in_ready=1, and an instruction accepted in that cycle is treated as correct-path.
- A misaligned taken result still goes through REDIR and flush; trap handling belongs to the consumer.

Optional Feature:
- Macro: BRU_STAT_EN.
- Defined:
  - Adds output ports stat_branches[31:0] and stat_taken[31:0].
  - Both counters reset to 0 on rst.
  - stat_branches increments on every out handshake of a conditional branch; stat_taken increments when that branch was taken.
  - Both wrap from 32'hFFFF_FFFF to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- BEQ with in_pc=0x8000_0010, in_imm=0x20, in_cmp=all-ones, out_ready=1 -> next cycle out_valid=1, out_pc=0x8000_0030, out_redirect=1, out_link=0x8000_0014; one cycle later flush=1 for exactly 1 cycle, in_ready=0 during REDIR.
- BNE with in_cmp=0, in_pc=0x8000_0000 -> out_pc=0x8000_0004, out_redirect=0, no flush; with continuous in_valid and out_ready=1, accepts one instruction per cycle.
- JALR with in_src1=0x8000_1003, in_imm=0 -> out_pc=0x8000_1002, out_misalign=1, out_redirect=1, flush after handshake.
- JAL with in_pc=0xFFFF_FFFF_FFFF_FFF8, in_imm=0x10 -> out_pc=0x8 (wrap), out_link=0xFFFF_FFFF_FFFF_FFFC.
- Taken branch held with out_ready=0 for 5 cycles while in_valid=1 -> outputs stable, in_ready=0, no flush; out_ready=1 -> flush next cycle, then IDLE. Same scenario with rst=1 on cycle 3 -> out_valid=0, out_pc=RESET_PC, no flush.
- With BRU_STAT_EN defined: 3 branches with outcomes taken, not-taken, taken -> stat_branches=3, stat_taken=2.
